// File: rtl/memory_arbiter.sv
// Arbitrates L1I read misses and L1D read/write traffic onto one backing-memory port.
// Define MEMORY_ARBITER_FAIRNESS_EN for alternating tie-breaks; the default is fixed L1D priority.
module memory_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // L1I port (read only)
  input  logic                  l1i_req_i,
  input  logic [ADDR_WIDTH-1:0] l1i_address_i,
  output logic                  l1i_ready_o,
  output logic [DATA_WIDTH-1:0] l1i_data_o,
  // L1D port
  input  logic                  l1d_req_i,
  input  logic                  l1d_write_i,
  input  logic [ADDR_WIDTH-1:0] l1d_address_i,
  input  logic [DATA_WIDTH-1:0] l1d_write_data_i,
  output logic                  l1d_ready_o,
  output logic [DATA_WIDTH-1:0] l1d_data_o,
  // Memory controller port
  output logic                  mem_valid_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_read_data_i,
  // Pipeline stalls
  output logic                  stall_l1i_o,
  output logic                  stall_l1d_o
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitI,
    StWaitD,
    StRespI,
    StRespD
  } state_e;

  state_e                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;  // 1: L1D was granted last
  logic                    mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0]   mem_write_data_q, mem_write_data_d;
  logic [DATA_WIDTH-1:0]   l1i_data_q, l1i_data_d;
  logic [DATA_WIDTH-1:0]   l1d_data_q, l1d_data_d;

  logic any_req;
  logic tie_to_d;
  logic pick_d;
  logic cmd_load;

  assign any_req = l1i_req_i | l1d_req_i;

`ifdef MEMORY_ARBITER_FAIRNESS_EN
  assign tie_to_d = ~last_grant_q;
`else
  // last_grant is still tracked, but it can never override the fixed L1D priority
  assign tie_to_d = 1'b1 | last_grant_q;
`endif

  assign pick_d   = l1d_req_i & (~l1i_req_i | tie_to_d);
  assign cmd_load = (state_q == StIdle) & any_req;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = pick_d ? StWaitD : StWaitI;
        end
      end
      StWaitI: begin
        if (mem_ack_i) begin
          state_d = StRespI;
        end
      end
      StWaitD: begin
        if (mem_ack_i) begin
          state_d = StRespD;
        end
      end
      StRespI, StRespD: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from the state
  always_comb begin
    mem_valid_o = 1'b0;
    l1i_ready_o = 1'b0;
    l1d_ready_o = 1'b0;
    unique case (state_q)
      StWaitI, StWaitD: mem_valid_o = 1'b1;
      StRespI:          l1i_ready_o = 1'b1;
      StRespD:          l1d_ready_o = 1'b1;
      default:          ;
    endcase
  end

  // Command and response datapath; L1I grants leave the write-data register untouched
  always_comb begin
    last_grant_d     = last_grant_q;
    mem_write_d      = mem_write_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    l1i_data_d       = l1i_data_q;
    l1d_data_d       = l1d_data_q;

    if (cmd_load) begin
      last_grant_d  = pick_d;
      mem_write_d   = pick_d & l1d_write_i;
      mem_address_d = pick_d ? l1d_address_i : l1i_address_i;
      if (pick_d) begin
        mem_write_data_d = l1d_write_data_i;
      end
    end

    if ((state_q == StWaitI) && mem_ack_i) begin
      l1i_data_d = mem_read_data_i;
    end
    if ((state_q == StWaitD) && mem_ack_i && !mem_write_q) begin
      l1d_data_d = mem_read_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q     <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      l1i_data_q       <= '0;
      l1d_data_q       <= '0;
    end else begin
      last_grant_q     <= last_grant_d;
      mem_write_q      <= mem_write_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      l1i_data_q       <= l1i_data_d;
      l1d_data_q       <= l1d_data_d;
    end
  end

  assign mem_write_o      = mem_write_q;
  assign mem_address_o    = mem_address_q;
  assign mem_write_data_o = mem_write_data_q;
  assign l1i_data_o       = l1i_data_q;
  assign l1d_data_o       = l1d_data_q;

  assign stall_l1i_o = l1i_req_i & ~l1i_ready_o;
  assign stall_l1d_o = l1d_req_i & ~l1d_ready_o;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table, tie sequence and
// randomized traffic against a transaction-level reference model.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        l1i_req;
  logic [31:0] l1i_address;
  logic        l1i_ready;
  logic [31:0] l1i_data;
  logic        l1d_req;
  logic        l1d_write;
  logic [31:0] l1d_address;
  logic [31:0] l1d_write_data;
  logic        l1d_ready;
  logic [31:0] l1d_data;
  logic        mem_valid;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_ack;
  logic [31:0] mem_read_data;
  logic        stall_l1i;
  logic        stall_l1d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .l1i_req_i       (l1i_req),
    .l1i_address_i   (l1i_address),
    .l1i_ready_o     (l1i_ready),
    .l1i_data_o      (l1i_data),
    .l1d_req_i       (l1d_req),
    .l1d_write_i     (l1d_write),
    .l1d_address_i   (l1d_address),
    .l1d_write_data_i(l1d_write_data),
    .l1d_ready_o     (l1d_ready),
    .l1d_data_o      (l1d_data),
    .mem_valid_o     (mem_valid),
    .mem_write_o     (mem_write),
    .mem_address_o   (mem_address),
    .mem_write_data_o(mem_write_data),
    .mem_ack_i       (mem_ack),
    .mem_read_data_i (mem_read_data),
    .stall_l1i_o     (stall_l1i),
    .stall_l1d_o     (stall_l1d)
  );

  typedef struct {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwr;
    logic [31:0] daddr;
    logic [31:0] dwd;
    logic        ack;
    logic [31:0] rdata;
  } in_t;

  typedef struct {
    logic        mv;
    logic        mw;
    logic [31:0] ma;
    logic [31:0] mwd;
    logic        ir;
    logic [31:0] idata;
    logic        dr;
    logic [31:0] ddata;
    logic        si;
    logic        sd;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  function automatic in_t mi(input logic r, input logic ireq, input logic [31:0] iaddr,
                             input logic dreq, input logic dwr, input logic [31:0] daddr,
                             input logic [31:0] dwd, input logic ack, input logic [31:0] rd);
    in_t x;
    x.rst = r;  x.ireq = ireq; x.iaddr = iaddr; x.dreq = dreq; x.dwr = dwr;
    x.daddr = daddr; x.dwd = dwd; x.ack = ack; x.rdata = rd;
    return x;
  endfunction

  function automatic out_t mo(input logic mv, input logic mw, input logic [31:0] ma,
                              input logic [31:0] mwd, input logic ir, input logic [31:0] idata,
                              input logic dr, input logic [31:0] ddata, input logic si,
                              input logic sd);
    out_t y;
    y.mv = mv; y.mw = mw; y.ma = ma; y.mwd = mwd; y.ir = ir; y.idata = idata;
    y.dr = dr; y.ddata = ddata; y.si = si; y.sd = sd;
    return y;
  endfunction

  task automatic drive(input in_t x);
    rst            = x.rst;
    l1i_req        = x.ireq;
    l1i_address    = x.iaddr;
    l1d_req        = x.dreq;
    l1d_write      = x.dwr;
    l1d_address    = x.daddr;
    l1d_write_data = x.dwd;
    mem_ack        = x.ack;
    mem_read_data  = x.rdata;
  endtask

  task automatic check(input string tag, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input out_t e);
    check(tag, "mem_valid", {31'b0, mem_valid}, {31'b0, e.mv});
    check(tag, "mem_write", {31'b0, mem_write}, {31'b0, e.mw});
    check(tag, "mem_address", mem_address, e.ma);
    check(tag, "mem_write_data", mem_write_data, e.mwd);
    check(tag, "l1i_ready", {31'b0, l1i_ready}, {31'b0, e.ir});
    check(tag, "l1i_data", l1i_data, e.idata);
    check(tag, "l1d_ready", {31'b0, l1d_ready}, {31'b0, e.dr});
    check(tag, "l1d_data", l1d_data, e.ddata);
    check(tag, "stall_l1i", {31'b0, stall_l1i}, {31'b0, e.si});
    check(tag, "stall_l1d", {31'b0, stall_l1d}, {31'b0, e.sd});
  endtask

  // One cycle: inputs set after the falling edge, outputs sampled just after.
  task automatic cycle(input string tag, input in_t x, input out_t e);
    @(negedge clk);
    drive(x);
    #1;
    check_outputs(tag, e);
  endtask

  // Transaction-level reference: phase 0 idle, 1 waiting on memory, 2 responding.
  int          m_phase;
  logic        m_owner_d;
  logic        m_last_d;
  logic        m_wr;
  logic [31:0] m_addr, m_wdata, m_idata, m_ddata;

  task automatic model_reset();
    m_phase = 0; m_owner_d = 1'b0; m_last_d = 1'b0; m_wr = 1'b0;
    m_addr = '0; m_wdata = '0; m_idata = '0; m_ddata = '0;
  endtask

  function automatic out_t model_out();
    out_t y;
    y.mv    = (m_phase == 1);
    y.mw    = m_wr;
    y.ma    = m_addr;
    y.mwd   = m_wdata;
    y.ir    = (m_phase == 2) && !m_owner_d;
    y.dr    = (m_phase == 2) && m_owner_d;
    y.idata = m_idata;
    y.ddata = m_ddata;
    y.si    = l1i_req && !y.ir;
    y.sd    = l1d_req && !y.dr;
    return y;
  endfunction

  task automatic model_step();
    logic d_wins;
    if (rst) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (l1i_req || l1d_req) begin
`ifdef MEMORY_ARBITER_FAIRNESS_EN
        d_wins = l1d_req && (!l1i_req || !m_last_d);
`else
        d_wins = l1d_req;
`endif
        m_owner_d = d_wins;
        m_last_d  = d_wins;
        m_addr    = d_wins ? l1d_address : l1i_address;
        m_wr      = d_wins && l1d_write;
        if (d_wins) m_wdata = l1d_write_data;
        m_phase   = 1;
      end
    end else if (m_phase == 1) begin
      if (mem_ack) begin
        if (!m_wr) begin
          if (m_owner_d) m_ddata = mem_read_data;
          else           m_idata = mem_read_data;
        end
        m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  vec_t tbl[18];
  in_t  z;

  initial begin
    z = mi(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(z);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Directed vectors: one row per cycle.
    tbl[0]  = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 0),
                mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{mi(0, 1, 32'h100, 0, 0, 0, 0, 0, 0),
                mo(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
    tbl[2]  = '{mi(0, 1, 32'h100, 0, 0, 0, 0, 1, 32'hDEADBEEF),
                mo(1, 0, 32'h100, 0, 0, 0, 0, 0, 1, 0)};
    tbl[3]  = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 0),
                mo(0, 0, 32'h100, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0)};
    tbl[4]  = '{mi(0, 0, 0, 1, 1, 32'h2000, 32'h12345678, 0, 0),
                mo(0, 0, 32'h100, 0, 0, 32'hDEADBEEF, 0, 0, 0, 1)};
    for (int k = 5; k <= 8; k++) begin
      tbl[k] = '{mi(0, 0, 0, 1, 1, 32'h2000, 32'h12345678, 0, 0),
                 mo(1, 1, 32'h2000, 32'h12345678, 0, 32'hDEADBEEF, 0, 0, 0, 1)};
    end
    tbl[9]  = '{mi(0, 0, 0, 1, 1, 32'h2000, 32'h12345678, 1, 32'h55555555),
                mo(1, 1, 32'h2000, 32'h12345678, 0, 32'hDEADBEEF, 0, 0, 0, 1)};
    tbl[10] = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 0),
                mo(0, 1, 32'h2000, 32'h12345678, 0, 32'hDEADBEEF, 1, 0, 0, 0)};
    tbl[11] = '{mi(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF),
                mo(0, 1, 32'h2000, 32'h12345678, 0, 32'hDEADBEEF, 0, 0, 0, 0)};
    tbl[12] = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 0),
                mo(0, 1, 32'h2000, 32'h12345678, 0, 32'hDEADBEEF, 0, 0, 0, 0)};
    tbl[13] = '{mi(0, 0, 0, 1, 0, 32'h300, 0, 0, 0),
                mo(0, 1, 32'h2000, 32'h12345678, 0, 32'hDEADBEEF, 0, 0, 0, 1)};
    tbl[14] = '{mi(0, 0, 0, 1, 0, 32'h300, 0, 0, 0),
                mo(1, 0, 32'h300, 0, 0, 32'hDEADBEEF, 0, 0, 0, 1)};
    tbl[15] = '{mi(1, 0, 0, 1, 0, 32'h300, 0, 0, 0),
                mo(1, 0, 32'h300, 0, 0, 32'hDEADBEEF, 0, 0, 0, 1)};
    tbl[16] = '{mi(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE),
                mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[17] = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 0),
                mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};

    for (int k = 0; k < 18; k++) begin
      cycle($sformatf("vec%0d", k), tbl[k].i, tbl[k].o);
    end

    // Tie: L1D first, then L1I while L1D is off, then L1D again; stalls held while waiting.
    cycle("tie0", mi(0, 1, 32'h10, 1, 0, 32'h20, 0, 0, 0),
          mo(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    cycle("tie1", mi(0, 1, 32'h10, 1, 0, 32'h20, 0, 1, 32'hA0A0),
          mo(1, 0, 32'h20, 0, 0, 0, 0, 0, 1, 1));
    cycle("tie2", mi(0, 1, 32'h10, 0, 0, 0, 0, 0, 0),
          mo(0, 0, 32'h20, 0, 0, 0, 1, 32'hA0A0, 1, 0));
    cycle("tie3", mi(0, 1, 32'h10, 0, 0, 0, 0, 0, 0),
          mo(0, 0, 32'h20, 0, 0, 0, 0, 32'hA0A0, 1, 0));
    cycle("tie4", mi(0, 1, 32'h10, 1, 0, 32'h20, 0, 1, 32'h1111),
          mo(1, 0, 32'h10, 0, 0, 0, 0, 32'hA0A0, 1, 1));
    cycle("tie5", mi(0, 0, 0, 1, 0, 32'h20, 0, 0, 0),
          mo(0, 0, 32'h10, 0, 1, 32'h1111, 0, 32'hA0A0, 0, 1));
    cycle("tie6", mi(0, 0, 0, 1, 0, 32'h20, 0, 0, 0),
          mo(0, 0, 32'h10, 0, 0, 32'h1111, 0, 32'hA0A0, 0, 1));
    cycle("tie7", mi(0, 0, 0, 1, 0, 32'h20, 0, 1, 32'h2222),
          mo(1, 0, 32'h20, 0, 0, 32'h1111, 0, 32'hA0A0, 0, 1));
    cycle("tie8", mi(0, 0, 0, 0, 0, 0, 0, 0, 0),
          mo(0, 0, 32'h20, 0, 0, 32'h1111, 1, 32'h2222, 0, 0));

    // Randomized traffic against the reference model, starting from reset.
    @(negedge clk);
    drive(mi(1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      out_t pre;
      @(negedge clk);
      pre = model_out();
      rst = ($urandom_range(63) == 0);
      if (l1i_req && pre.ir) begin
        l1i_req = 1'b0;
      end else if (!l1i_req && $urandom_range(2) == 0) begin
        l1i_req     = 1'b1;
        l1i_address = $urandom;
      end
      if (l1d_req && pre.dr) begin
        l1d_req = 1'b0;
      end else if (!l1d_req && $urandom_range(2) == 0) begin
        l1d_req        = 1'b1;
        l1d_write      = $urandom_range(1) == 1;
        l1d_address    = $urandom;
        l1d_write_data = $urandom;
      end
      mem_ack       = ($urandom_range(2) == 0);
      mem_read_data = $urandom;
      #1;
      check_outputs($sformatf("rnd%0d", n), model_out());
      model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
